// File: rtl/cordic_pipe_if.sv
// Sample-in / result-out bundle for cordic_pipe; slave modport is the engine side.
interface cordic_pipe_if #(
   parameter int XYWIDTH  = 16,
   parameter int ZWIDTH   = 32,
   parameter int TAGWIDTH = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_mode;
   logic signed [XYWIDTH-1:0] x0;
   logic signed [XYWIDTH-1:0] y0;
   logic [ZWIDTH-1:0]         z0;
   logic [TAGWIDTH-1:0]       in_tag;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [XYWIDTH+1:0] xout;
   logic signed [XYWIDTH+1:0] yout;
   logic [ZWIDTH-1:0]         zout;
   logic                      out_mode;
   logic [TAGWIDTH-1:0]       out_tag;

   modport slave (
      input  in_valid, in_mode, x0, y0, z0, in_tag, out_ready,
      output in_ready, out_valid, xout, yout, zout, out_mode, out_tag
   );

   modport master (
      output in_valid, in_mode, x0, y0, z0, in_tag, out_ready,
      input  in_ready, out_valid, xout, yout, zout, out_mode, out_tag
   );
endinterface

// File: rtl/cordic_pipe.sv
// Pipelined rotation/vectoring CORDIC, latency STAGE+1 (STAGE+2 with CORDIC_GAIN_COMP_EN).
// in_ready mirrors out_ready; every stage, valid bits included, holds while out_ready is low.
module cordic_pipe #(
   parameter int XYWIDTH  = 16,
   parameter int ZWIDTH   = 32,
   parameter int STAGE    = 16,
   parameter int TAGWIDTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   cordic_pipe_if.slave bus
);
   localparam int W = XYWIDTH + 2;
   localparam logic [127:0] TWO_PI_Q60 = 128'h6487ED5110B4611A;
   localparam logic [ZWIDTH-1:0] QUARTER = {2'b01, {(ZWIDTH-2){1'b0}}};

   // atan(2^-i) as a Q60 Taylor series, then scaled to binary angle with rounding.
   function automatic logic [ZWIDTH-1:0] atan_one(input int i);
      logic [127:0]      acc;
      logic [127:0]      term;
      logic [127:0]      num;
      logic [ZWIDTH-1:0] res;
      acc = '0;
      if (i == 0) begin
         res = {3'b001, {(ZWIDTH-3){1'b0}}};
      end else begin
         for (int k = 1; k < 64; k += 2) begin
            if (i * k <= 60) begin
               term = (128'd1 << (60 - i * k)) / 128'(k);
               if (((k >> 1) & 1) == 1) acc = acc - term;
               else                     acc = acc + term;
            end
         end
         num = (acc << ZWIDTH) + (TWO_PI_Q60 >> 1);
         res = ZWIDTH'(num / TWO_PI_Q60);
      end
      return res;
   endfunction

   function automatic logic [STAGE*ZWIDTH-1:0] atan_tab();
      logic [STAGE*ZWIDTH-1:0] t;
      t = '0;
      for (int i = 0; i < STAGE; i++) t[i*ZWIDTH +: ZWIDTH] = atan_one(i);
      return t;
   endfunction

   localparam logic [STAGE*ZWIDTH-1:0] ATAN_TAB = atan_tab();

   logic signed [W-1:0]   x_q   [0:STAGE];
   logic signed [W-1:0]   x_d   [0:STAGE];
   logic signed [W-1:0]   y_q   [0:STAGE];
   logic signed [W-1:0]   y_d   [0:STAGE];
   logic [ZWIDTH-1:0]     z_q   [0:STAGE];
   logic [ZWIDTH-1:0]     z_d   [0:STAGE];
   logic                  mode_q[0:STAGE];
   logic                  mode_d[0:STAGE];
   logic [TAGWIDTH-1:0]   tag_q [0:STAGE];
   logic [TAGWIDTH-1:0]   tag_d [0:STAGE];
   logic                  vld_q [0:STAGE];
   logic                  vld_d [0:STAGE];
   logic                  adv;
   logic signed [W-1:0]   xin;
   logic signed [W-1:0]   yin;

   assign adv          = bus.out_ready;
   assign bus.in_ready = adv;
   assign xin          = {{2{bus.x0[XYWIDTH-1]}}, bus.x0};
   assign yin          = {{2{bus.y0[XYWIDTH-1]}}, bus.y0};

   always_comb begin
      x_d[0]    = xin;
      y_d[0]    = yin;
      z_d[0]    = bus.z0;
      mode_d[0] = bus.in_mode;
      tag_d[0]  = bus.in_tag;
      vld_d[0]  = bus.in_valid;
      // Pre-rotation folds the input into the right half-plane the iterations converge over.
      if (!bus.in_mode) begin
         case (bus.z0[ZWIDTH-1 -: 2])
            2'b01: begin
               x_d[0] = -yin;
               y_d[0] = xin;
               z_d[0] = {2'b00, bus.z0[ZWIDTH-3:0]};
            end
            2'b10: begin
               x_d[0] = yin;
               y_d[0] = -xin;
               z_d[0] = {2'b11, bus.z0[ZWIDTH-3:0]};
            end
            default: ;
         endcase
      end else if (xin[W-1]) begin
         if (!yin[W-1]) begin
            x_d[0] = yin;
            y_d[0] = -xin;
            z_d[0] = bus.z0 + QUARTER;
         end else begin
            x_d[0] = -yin;
            y_d[0] = xin;
            z_d[0] = bus.z0 - QUARTER;
         end
      end

      for (int i = 0; i < STAGE; i++) begin
         if (mode_q[i] ? !y_q[i][W-1] : z_q[i][ZWIDTH-1]) begin
            x_d[i+1] = x_q[i] + (y_q[i] >>> i);
            y_d[i+1] = y_q[i] - (x_q[i] >>> i);
            z_d[i+1] = z_q[i] + ATAN_TAB[i*ZWIDTH +: ZWIDTH];
         end else begin
            x_d[i+1] = x_q[i] - (y_q[i] >>> i);
            y_d[i+1] = y_q[i] + (x_q[i] >>> i);
            z_d[i+1] = z_q[i] - ATAN_TAB[i*ZWIDTH +: ZWIDTH];
         end
         mode_d[i+1] = mode_q[i];
         tag_d[i+1]  = tag_q[i];
         vld_d[i+1]  = vld_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= STAGE; i++) begin
            x_q[i]    <= '0;
            y_q[i]    <= '0;
            z_q[i]    <= '0;
            mode_q[i] <= 1'b0;
            tag_q[i]  <= '0;
            vld_q[i]  <= 1'b0;
         end
      end else if (adv) begin
         x_q    <= x_d;
         y_q    <= y_d;
         z_q    <= z_d;
         mode_q <= mode_d;
         tag_q  <= tag_d;
         vld_q  <= vld_d;
      end
   end

`ifdef CORDIC_GAIN_COMP_EN
   localparam int PW = W + 19;
   localparam logic signed [PW-1:0] INV_K = PW'(79594);
   localparam logic signed [PW-1:0] RND   = PW'(65536);

   // 1/K in Q0.17, rounded half-up before the arithmetic shift back.
   function automatic logic signed [W-1:0] gain(input logic signed [W-1:0] v);
      logic signed [PW-1:0] p;
      p = PW'(v) * INV_K + RND;
      return W'(p >>> 17);
   endfunction

   logic signed [W-1:0] xg_q, xg_d;
   logic signed [W-1:0] yg_q, yg_d;
   logic [ZWIDTH-1:0]   zg_q;
   logic                mg_q;
   logic [TAGWIDTH-1:0] tg_q;
   logic                vg_q;

   assign xg_d = gain(x_q[STAGE]);
   assign yg_d = gain(y_q[STAGE]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xg_q <= '0;
         yg_q <= '0;
         zg_q <= '0;
         mg_q <= 1'b0;
         tg_q <= '0;
         vg_q <= 1'b0;
      end else if (adv) begin
         xg_q <= xg_d;
         yg_q <= yg_d;
         zg_q <= z_q[STAGE];
         mg_q <= mode_q[STAGE];
         tg_q <= tag_q[STAGE];
         vg_q <= vld_q[STAGE];
      end
   end

   assign bus.out_valid = vg_q;
   assign bus.xout      = xg_q;
   assign bus.yout      = yg_q;
   assign bus.zout      = zg_q;
   assign bus.out_mode  = mg_q;
   assign bus.out_tag   = tg_q;
`else
   assign bus.out_valid = vld_q[STAGE];
   assign bus.xout      = x_q[STAGE];
   assign bus.yout      = y_q[STAGE];
   assign bus.zout      = z_q[STAGE];
   assign bus.out_mode  = mode_q[STAGE];
   assign bus.out_tag   = tag_q[STAGE];
`endif
endmodule
